writeback_stage_p: RTL and testbench
====================================

Name: writeback_stage_p

Overview:
Parametrised MEM/WB pipeline register plus writeback result selection for the RV32I pipeline.
- Generalises the 2-way ALU/memory result mux to a 4-way select (ALU, load data, PC+4, immediate).
- Adds sub-word load extraction, stall/flush control and x0 write suppression.
- Sits between the memory cycle and the register-file write port; drives the hazard unit's forwarding inputs.

Parameters:
XLEN, 32, datapath width (32 only is verified; 64 must elaborate).
RA_W, 5, register address width.

Ports:
clk  in  1  pipeline clock, rising edge.
rst  in  1  asynchronous reset, active-low.
StallW  in  1  hold WB register contents.
FlushW  in  1  insert bubble into WB.
RegWriteM  in  1  instruction writes rd.
ResultSrcM  in  2  00 ALU, 01 load data, 10 PC+4, 11 immediate.
LoadTypeM  in  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
RdM  in  RA_W  destination register.
ALU_ResultM  in  XLEN  ALU result / load address.
ReadDataM  in  XLEN  raw word read from data memory.
PCPlus4M  in  XLEN  PC+4 of the instruction.
ImmExtM  in  XLEN  extended immediate (LUI).
RegWriteW  out  1  register-file write enable.
RdW  out  RA_W  register-file write address.
ResultW  out  XLEN  register-file write data.
ValidW  out  1  WB slot holds a real instruction.

Behaviour:
- Reset (rst=0, asynchronous): all WB registers cleared. ValidW=0, RegWriteW=0, RdW=0, ResultW=0.
- Reset has priority over every other input. Deassertion takes effect at the next rising edge.
- Capture priority on each rising edge: FlushW > StallW > load.
  - FlushW=1: ValidW_q=0, RegWrite_q=0. Data fields are don't-care but cleared to 0.
  - StallW=1 (no flush): all registers hold.
  - Otherwise: all *M inputs are captured; ValidW_q=1.
- Latency: one cycle from the M inputs to the W outputs. ResultW is combinational from the registered fields, with no additional register.
- RegWriteW = RegWrite_q AND ValidW_q AND (RdW != 0). Writes to x0 are never issued.
- Result select, on registered ResultSrc:
  - 00 → ALU_Result.
  - 01 → extended load data.
  - 10 → PCPlus4.
  - 11 → ImmExt.
- Load extraction:
  - Byte offset = ALU_Result_q[1:0].
  - LB/LBU select byte [8*off +: 8].
  - LH/LHU select half by off[1]; off[0] is ignored (misalignment is trapped upstream, out of scope).
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW and the reserved codes 011/110/111 pass the full word.
  - Little-endian.
- Simultaneous FlushW and StallW: flush wins.
- Reset mid-stall: outputs clear immediately; the held instruction is lost.

Optional Feature:
SUBWORD_LOAD_EN
- Defined: load extraction as above.
- Undefined: load data passes ReadData unchanged for all LoadType values. LoadTypeM is ignored and need not be registered (RV32I word-only builds).

Decomposition:
- Package rv_wb_pkg:
  - ResultSrc encodings RES_ALU/RES_MEM/RES_PC4/RES_IMM.
  - Load funct3 constants LD_B/LD_H/LD_W/LD_BU/LD_HU.
  - XLEN default.
- One sub-module: load_extend. Combinational; inputs word, offset, load type; output extended XLEN value. It is the unit under SUBWORD_LOAD_EN.

Test Plan:
- Reset: hold rst=0 with random M inputs → ValidW=0, RegWriteW=0, ResultW=0. Release rst; next edge with RegWriteM=1, RdM=5, ResultSrcM=00, ALU_ResultM=0x1234 → RdW=5, ResultW=0x1234, RegWriteW=1.
- Loads: ReadDataM=0x80F17F22, ResultSrcM=01.
  - LB off=3 → 0xFFFFFF80.
  - LBU off=3 → 0x00000080.
  - LH off=2 → 0xFFFF80F1.
  - LHU off=0 → 0x00007F22.
  - LW → 0x80F17F22.
  - With SUBWORD_LOAD_EN undefined, all five → 0x80F17F22.
- Select: ResultSrcM=10 with PCPlus4M=0x104 → ResultW=0x104. ResultSrcM=11 with ImmExtM=0xABCDE000 → ResultW=0xABCDE000.
- x0: RegWriteM=1, RdM=0 → RegWriteW=0, ValidW=1.
- Stall/flush:
  - StallW=1 for 3 cycles while M inputs change → W outputs constant.
  - FlushW=1 together with StallW=1 → next edge ValidW=0, RegWriteW=0.
- Asynchronous reset mid-operation: assert rst=0 between clock edges while ValidW=1 → outputs clear before the next edge.

Source files
------------

// File: rtl/rv_wb_pkg.sv
// Shared encodings for the RV32I writeback stage: result-select codes,
// load funct3 codes and the default datapath width.
package rv_wb_pkg;

   localparam int XLEN_DEF = 32;

   // Writeback result source select
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;

   // Load funct3 codes
   localparam logic [2:0] LD_B  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_W  = 3'b010;
   localparam logic [2:0] LD_BU = 3'b100;
   localparam logic [2:0] LD_HU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Sub-word load extraction: picks the addressed byte/halfword out of the
// raw little-endian memory word and sign- or zero-extends it to XLEN.
// Halfword selection looks only at offset[1]; misaligned halves are
// trapped before they reach this stage.
module load_extend
   import rv_wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] word_i,
   input  logic [1:0]      offset_i,
   input  logic [2:0]      load_type_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Select the addressed byte and halfword, then extend per load type
   always_comb begin
      byte_sel = word_i[8*offset_i +: 8];
      half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
      data_o   = word_i;
      case (load_type_i)
         LD_B:    data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LD_H:    data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
         LD_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sel};
         LD_HU:   data_o = {{(XLEN-16){1'b0}}, half_sel};
         LD_W:    data_o = word_i;
         default: data_o = word_i;   // reserved codes pass the full word
      endcase
   end

endmodule

// File: rtl/writeback_stage_p.sv
// MEM/WB pipeline register plus writeback result selection.
// Capture priority per edge: FlushW > StallW > load. ValidW marks a real
// instruction in the WB slot; RegWriteW is only raised for a valid
// instruction with a nonzero destination, so x0 is never written.
// Optional feature macro: SUBWORD_LOAD_EN (byte/halfword load extraction;
// when undefined, load data is the raw memory word and LoadTypeM is ignored).
module writeback_stage_p
   import rv_wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallW,
   input  logic            FlushW,
   input  logic            RegWriteM,
   input  logic [1:0]      ResultSrcM,
   input  logic [2:0]      LoadTypeM,
   input  logic [RA_W-1:0] RdM,
   input  logic [XLEN-1:0] ALU_ResultM,
   input  logic [XLEN-1:0] ReadDataM,
   input  logic [XLEN-1:0] PCPlus4M,
   input  logic [XLEN-1:0] ImmExtM,
   output logic            RegWriteW,
   output logic [RA_W-1:0] RdW,
   output logic [XLEN-1:0] ResultW,
   output logic            ValidW
);

   logic            valid_q,      valid_d;
   logic            reg_write_q,  reg_write_d;
   logic [1:0]      result_src_q, result_src_d;
   logic [RA_W-1:0] rd_q,         rd_d;
   logic [XLEN-1:0] alu_result_q, alu_result_d;
   logic [XLEN-1:0] read_data_q,  read_data_d;
   logic [XLEN-1:0] pc_plus4_q,   pc_plus4_d;
   logic [XLEN-1:0] imm_ext_q,    imm_ext_d;
   logic [XLEN-1:0] load_data;

`ifdef SUBWORD_LOAD_EN
   logic [2:0] load_type_q, load_type_d;
`endif

   // Next-state: flush clears to a bubble, stall holds, otherwise capture M
   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      result_src_d = result_src_q;
      rd_d         = rd_q;
      alu_result_d = alu_result_q;
      read_data_d  = read_data_q;
      pc_plus4_d   = pc_plus4_q;
      imm_ext_d    = imm_ext_q;
`ifdef SUBWORD_LOAD_EN
      load_type_d  = load_type_q;
`endif
      if (FlushW) begin
         valid_d      = 1'b0;
         reg_write_d  = 1'b0;
         result_src_d = '0;
         rd_d         = '0;
         alu_result_d = '0;
         read_data_d  = '0;
         pc_plus4_d   = '0;
         imm_ext_d    = '0;
`ifdef SUBWORD_LOAD_EN
         load_type_d  = '0;
`endif
      end else if (!StallW) begin
         valid_d      = 1'b1;
         reg_write_d  = RegWriteM;
         result_src_d = ResultSrcM;
         rd_d         = RdM;
         alu_result_d = ALU_ResultM;
         read_data_d  = ReadDataM;
         pc_plus4_d   = PCPlus4M;
         imm_ext_d    = ImmExtM;
`ifdef SUBWORD_LOAD_EN
         load_type_d  = LoadTypeM;
`endif
      end
   end

   // WB pipeline register with asynchronous active-low clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         result_src_q <= '0;
         rd_q         <= '0;
         alu_result_q <= '0;
         read_data_q  <= '0;
         pc_plus4_q   <= '0;
         imm_ext_q    <= '0;
`ifdef SUBWORD_LOAD_EN
         load_type_q  <= '0;
`endif
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         result_src_q <= result_src_d;
         rd_q         <= rd_d;
         alu_result_q <= alu_result_d;
         read_data_q  <= read_data_d;
         pc_plus4_q   <= pc_plus4_d;
         imm_ext_q    <= imm_ext_d;
`ifdef SUBWORD_LOAD_EN
         load_type_q  <= load_type_d;
`endif
      end
   end

`ifdef SUBWORD_LOAD_EN
   load_extend #(
      .XLEN(XLEN)
   ) u_load_extend (
      .word_i      (read_data_q),
      .offset_i    (alu_result_q[1:0]),
      .load_type_i (load_type_q),
      .data_o      (load_data)
   );
`else
   // Word-only build: the load type has no effect on the result
   logic unused_load_type;
   assign unused_load_type = ^LoadTypeM;
   assign load_data        = read_data_q;
`endif

   // Result select on the registered source code
   always_comb begin
      ResultW = alu_result_q;
      case (result_src_q)
         RES_ALU: ResultW = alu_result_q;
         RES_MEM: ResultW = load_data;
         RES_PC4: ResultW = pc_plus4_q;
         RES_IMM: ResultW = imm_ext_q;
         default: ResultW = alu_result_q;
      endcase
   end

   assign ValidW    = valid_q;
   assign RdW       = rd_q;
   assign RegWriteW = reg_write_q & valid_q & (rd_q != '0);

endmodule

// File: tb/tb_writeback_stage_p.sv
// Self-checking bench for writeback_stage_p. The driver pushes the expected
// W outputs for each cycle it drives; a monitor pops and compares on the
// falling edge after the capturing rising edge.
module tb_writeback_stage_p;

   logic        clk;
   logic        rst;
   logic        StallW;
   logic        FlushW;
   logic        RegWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  LoadTypeM;
   logic [4:0]  RdM;
   logic [31:0] ALU_ResultM;
   logic [31:0] ReadDataM;
   logic [31:0] PCPlus4M;
   logic [31:0] ImmExtM;
   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [31:0] ResultW;
   logic        ValidW;

   // Expected entry packing: {ValidW, RegWriteW, RdW, ResultW}
   logic [38:0] exp_q[$];
   string       name_q[$];
   int          checks;
   int          errors;

   localparam logic [31:0] LD_WORD = 32'h80F17F22;

   writeback_stage_p #(
      .XLEN(32),
      .RA_W(5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .StallW      (StallW),
      .FlushW      (FlushW),
      .RegWriteM   (RegWriteM),
      .ResultSrcM  (ResultSrcM),
      .LoadTypeM   (LoadTypeM),
      .RdM         (RdM),
      .ALU_ResultM (ALU_ResultM),
      .ReadDataM   (ReadDataM),
      .PCPlus4M    (PCPlus4M),
      .ImmExtM     (ImmExtM),
      .RegWriteW   (RegWriteW),
      .RdW         (RdW),
      .ResultW     (ResultW),
      .ValidW      (ValidW)
   );

   // Clock and initial reset state
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [38:0] o(input logic v, input logic rw,
                                     input logic [4:0] rd, input logic [31:0] res);
      return {v, rw, rd, res};
   endfunction

   function automatic logic [31:0] ld_exp(input logic [31:0] sub_val);
`ifdef SUBWORD_LOAD_EN
      return sub_val;
`else
      return (sub_val == sub_val) ? LD_WORD : LD_WORD;
`endif
   endfunction

   task automatic compare(input string nm, input logic [38:0] exp);
      logic [38:0] act;
      act = {ValidW, RegWriteW, RdW, ResultW};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got valid=%0b rw=%0b rd=%0d res=%h, expected valid=%0b rw=%0b rd=%0d res=%h",
                  nm, act[38], act[37], act[36:32], act[31:0],
                  exp[38], exp[37], exp[36:32], exp[31:0]);
      end
   endtask

   // Driver: set inputs mid-low-phase and push the outputs expected after the next edge
   task automatic drive(input string nm, input logic rst_v, input logic st, input logic fl,
                        input logic rw, input logic [1:0] src, input logic [2:0] lt,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] pc4, input logic [31:0] imm, input logic [38:0] exp);
      @(negedge clk);
      #1;
      rst         = rst_v;
      StallW      = st;
      FlushW      = fl;
      RegWriteM   = rw;
      ResultSrcM  = src;
      LoadTypeM   = lt;
      RdM         = rd;
      ALU_ResultM = alu;
      ReadDataM   = rdata;
      PCPlus4M    = pc4;
      ImmExtM     = imm;
      exp_q.push_back(exp);
      name_q.push_back(nm);
   endtask

   task automatic drive_rand_in_reset(input string nm);
      drive(nm, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 5'($urandom_range(1, 31)), $urandom, $urandom,
            $urandom, $urandom, o(1'b0, 1'b0, 5'd0, 32'h0));
   endtask

   // Monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) compare(name_q.pop_front(), exp_q.pop_front());
      end
   end

   // Stimulus
   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b0;
      StallW      = 1'b0;
      FlushW      = 1'b0;
      RegWriteM   = 1'b0;
      ResultSrcM  = 2'b00;
      LoadTypeM   = 3'b000;
      RdM         = 5'd0;
      ALU_ResultM = 32'h0;
      ReadDataM   = 32'h0;
      PCPlus4M    = 32'h0;
      ImmExtM     = 32'h0;

      // Reset held with random M inputs
      for (int i = 0; i < 3; i++) drive_rand_in_reset("reset_hold");

      // First instruction after release
      drive("first_alu", 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 5'd5, 32'h1234, 32'h0,
            32'h0, 32'h0, o(1'b1, 1'b1, 5'd5, 32'h1234));

      // Loads from the fixed word
      drive("lb_off3", 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000, 5'd7, 32'h1003, LD_WORD,
            32'h0, 32'h0, o(1'b1, 1'b1, 5'd7, ld_exp(32'hFFFFFF80)));
      drive("lbu_off3", 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 3'b100, 5'd7, 32'h1003, LD_WORD,
            32'h0, 32'h0, o(1'b1, 1'b1, 5'd7, ld_exp(32'h00000080)));
      drive("lh_off2", 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 3'b001, 5'd8, 32'h2002, LD_WORD,
            32'h0, 32'h0, o(1'b1, 1'b1, 5'd8, ld_exp(32'hFFFF80F1)));
      drive("lhu_off0", 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 3'b101, 5'd8, 32'h2000, LD_WORD,
            32'h0, 32'h0, o(1'b1, 1'b1, 5'd8, ld_exp(32'h00007F22)));
      drive("lw", 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 3'b010, 5'd9, 32'h3000, LD_WORD,
            32'h0, 32'h0, o(1'b1, 1'b1, 5'd9, LD_WORD));
      drive("lb_off1", 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000, 5'd10, 32'h3001, LD_WORD,
            32'h0, 32'h0, o(1'b1, 1'b1, 5'd10, ld_exp(32'h0000007F)));
      drive("lh_off3_ign0", 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 3'b001, 5'd11, 32'h3003, LD_WORD,
            32'h0, 32'h0, o(1'b1, 1'b1, 5'd11, ld_exp(32'hFFFF80F1)));
      drive("ld_reserved", 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 3'b111, 5'd12, 32'h3002, LD_WORD,
            32'h0, 32'h0, o(1'b1, 1'b1, 5'd12, LD_WORD));

      // PC+4 and immediate select
      drive("sel_pc4", 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 5'd1, 32'hDEAD0000, LD_WORD,
            32'h104, 32'h0, o(1'b1, 1'b1, 5'd1, 32'h104));
      drive("sel_imm", 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 3'b000, 5'd2, 32'hDEAD0000, LD_WORD,
            32'h104, 32'hABCDE000, o(1'b1, 1'b1, 5'd2, 32'hABCDE000));

      // x0 suppression and RegWrite=0
      drive("x0_write", 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 5'd0, 32'h55, 32'h0,
            32'h0, 32'h0, o(1'b1, 1'b0, 5'd0, 32'h55));
      drive("no_write", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd3, 32'h66, 32'h0,
            32'h0, 32'h0, o(1'b1, 1'b0, 5'd3, 32'h66));

      // Stall holds the W contents while M inputs change
      drive("pre_stall", 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 5'd9, 32'hAAAA, 32'h0,
            32'h0, 32'h0, o(1'b1, 1'b1, 5'd9, 32'hAAAA));
      for (int i = 1; i <= 3; i++)
         drive("stall_hold", 1'b1, 1'b1, 1'b0, 1'b1, 2'(i), 3'b000, 5'(12 + i), 32'h1111 * i,
               32'h2222 * i, 32'h3333 * i, 32'h4444 * i, o(1'b1, 1'b1, 5'd9, 32'hAAAA));

      // Flush beats stall
      drive("flush_stall", 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 3'b000, 5'd4, 32'h7777, 32'h0,
            32'h0, 32'h0, o(1'b0, 1'b0, 5'd0, 32'h0));
      drive("after_flush", 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 5'd6, 32'h600D, 32'h0,
            32'h0, 32'h0, o(1'b1, 1'b1, 5'd6, 32'h600D));
      drive("flush_only", 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 3'b000, 5'd6, 32'h600D, 32'h0,
            32'h200, 32'h0, o(1'b0, 1'b0, 5'd0, 32'h0));
      drive("pre_areset", 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 5'd21, 32'hCAFE, 32'h0,
            32'h0, 32'h0, o(1'b1, 1'b1, 5'd21, 32'hCAFE));

      // Asynchronous reset between edges while ValidW=1
      @(negedge clk);
      #3;
      rst = 1'b0;
      #1;
      compare("async_reset", o(1'b0, 1'b0, 5'd0, 32'h0));

      drive("areset_hold", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 5'd21, 32'hCAFE, 32'h0,
            32'h0, 32'h0, o(1'b0, 1'b0, 5'd0, 32'h0));
      drive("post_areset", 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 3'b000, 5'd31, 32'h0, 32'h0,
            32'h0, 32'h12345000, o(1'b1, 1'b1, 5'd31, 32'h12345000));

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
